// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, state type and helpers for the 7-segment scan driver.
//   SEG_BLANK  - all cathodes off (active-low)
//   AN_OFF     - all anodes off (active-low)
//   SEG_TABLE  - hex digit to {g,f,e,d,c,b,a} active-low pattern
//   clog2      - ceil(log2(n)), minimum 1, for sizing counters
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // ST_IDLE: held in reset, nothing on the display.
    // ST_SCAN: free-running slot/digit scan.
    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } scan_state_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((longint'(1) << r) < longint'(n)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/hex7seg_decode.sv
// hex7seg_decode: combinational hex digit to 7-segment pattern.
//   hex - 4-bit digit value
//   seg - cathodes {g,f,e,d,c,b,a}, active-low
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[hex];
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed 4-digit common-anode 7-segment driver.
//   clk         - master clock
//   clr_n       - synchronous active-low reset
//   value       - four hex digits, digit 0 in value[3:0] (rightmost)
//   dp_in       - decimal point request per digit, active-high
//   digit_en    - digit enable per digit, active-high
//   an          - anode drives, active-low, an[k] selects digit k
//   seg         - cathodes {g,f,e,d,c,b,a}, active-low
//   dp          - decimal point cathode, active-low
//   frame_start - one-cycle pulse in the first cycle of each 4-slot frame
// Each digit gets a SCAN_DIV-cycle slot whose first BLANK_CYC cycles are dark.
// The inputs are snapshotted once per frame so a frame never mixes values.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 131072,
    parameter int unsigned BLANK_CYC = 1024
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    localparam int unsigned    CW        = clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK_CYC);

    // state/cnt/idx describe the position of the cycle currently on the pins.
    scan_state_t   state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;

    logic [15:0] snap_val;
    logic [3:0]  snap_dp;
    logic [3:0]  snap_en;

    logic        capture;
    logic [15:0] eff_val;
    logic [3:0]  eff_dp;
    logic [3:0]  eff_en;
    logic [3:0]  digit;
    logic [6:0]  digit_seg;

    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;
    logic        frame_start_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state logic: leaving IDLE lands on slot 0, count 0 (frame start).
    always_comb begin
        state_nxt = ST_SCAN;
        cnt_nxt   = '0;
        idx_nxt   = '0;
        if (state == ST_SCAN) begin
            if (cnt == CNT_LAST) begin
                idx_nxt = idx + 2'd1;
            end else begin
                cnt_nxt = cnt + 1'b1;
                idx_nxt = idx;
            end
        end
    end

    // Snapshot taken on the edge closing the frame_start cycle.
    assign capture = (state == ST_SCAN) && (cnt == '0) && (idx == 2'd0);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            snap_val <= '0;
            snap_dp  <= '0;
            snap_en  <= '0;
        end else if (capture) begin
            snap_val <= value;
            snap_dp  <= dp_in;
            snap_en  <= digit_en;
        end
    end

    // Outputs are registered from the next position, so the capture edge must
    // see the values being captured (matters when BLANK_CYC is 1).
    assign eff_val = capture ? value    : snap_val;
    assign eff_dp  = capture ? dp_in    : snap_dp;
    assign eff_en  = capture ? digit_en : snap_en;
    assign digit   = eff_val[{idx_nxt, 2'b00} +: 4];

    hex7seg_decode u_decode (
        .hex (digit),
        .seg (digit_seg)
    );

    // Output logic
    always_comb begin
        an_nxt          = AN_OFF;
        seg_nxt         = SEG_BLANK;
        dp_nxt          = 1'b1;
        frame_start_nxt = (cnt_nxt == '0) && (idx_nxt == 2'd0);
        if ((cnt_nxt >= CNT_BLANK) && eff_en[idx_nxt]) begin
            an_nxt  = ~(4'b0001 << idx_nxt);
            seg_nxt = digit_seg;
            dp_nxt  = ~eff_dp[idx_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            an          <= AN_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= an_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: randomized self-checking bench for seg_scan_driver.
// Reference model tracks elapsed cycles since scan start and a frame snapshot,
// deriving slot, blanking and pattern arithmetically each cycle.
module tb_seg_scan_driver;

    localparam int SD = 16;
    localparam int BC = 4;
    localparam int FRAME = 4 * SD;

    localparam logic [6:0] REF_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        clk = 1'b0;
    logic        clr_n;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;

    int n_vec = 0;
    int n_err = 0;

    // Model state: t = cycles since scan start, -1 while in reset.
    int          t = -1;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp  = '0;
    logic [3:0]  m_en  = '0;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .SCAN_DIV  (SD),
        .BLANK_CYC (BC)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .value       (value),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Advance the model across the coming posedge using the inputs it will sample.
    task automatic model_step();
        if (!clr_n) begin
            t     = -1;
            m_val = '0;
            m_dp  = '0;
            m_en  = '0;
        end else begin
            if (t >= 0 && (t % FRAME) == 0) begin
                m_val = value;
                m_dp  = dp_in;
                m_en  = digit_en;
            end
            t = (t < 0) ? 0 : t + 1;
        end
    endtask

    task automatic check_cycle();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fs;
        logic [15:0] shifted;
        int slot;
        int off;
        e_an  = 4'hF;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        e_fs  = 1'b0;
        if (t >= 0) begin
            slot = (t / SD) % 4;
            off  = t % SD;
            e_fs = ((t % FRAME) == 0);
            if (off >= BC && m_en[slot]) begin
                e_an    = 4'(15 - (1 << slot));
                shifted = m_val >> (4 * slot);
                e_seg   = REF_SEG[shifted[3:0]];
                e_dp    = !m_dp[slot];
            end
        end
        check("an", 16'(an), 16'(e_an));
        check("seg", 16'(seg), 16'(e_seg));
        check("dp", 16'(dp), 16'(e_dp));
        check("frame_start", 16'(frame_start), 16'(e_fs));
    endtask

    task automatic run(input int n);
        repeat (n) begin
            model_step();
            @(negedge clk);
            check_cycle();
        end
    endtask

    initial begin
        clr_n    = 1'b0;
        value    = '0;
        dp_in    = '0;
        digit_en = '0;

        // Reset hold, release, steady value across three frame starts
        run(5);
        clr_n    = 1'b1;
        value    = 16'h12AF;
        digit_en = 4'hF;
        dp_in    = 4'h0;
        run(130);

        // Snapshot coherence: change mid-frame only shows next frame
        clr_n = 1'b0;
        value = 16'h0000;
        run(2);
        clr_n = 1'b1;
        run(10);
        value = 16'h8888;
        run(130);

        // Enables and decimal points
        value    = 16'h3C5E;
        digit_en = 4'b0101;
        dp_in    = 4'b0100;
        run(70);

        // Reset in the middle of slot 2 drive phase
        clr_n = 1'b0;
        run(1);
        clr_n    = 1'b1;
        value    = 16'h4321;
        digit_en = 4'hF;
        dp_in    = 4'b1010;
        run(37);
        clr_n = 1'b0;
        run(3);
        clr_n = 1'b1;
        run(80);

        // Full decode sweep, one value per frame
        dp_in = 4'h0;
        for (int i = 0; i < 16; i++) begin
            value = 16'(i * 16'h1111);
            run(FRAME);
        end

        // Random inputs at random times with occasional resets
        for (int i = 0; i < 16; i++) begin
            value    = 16'($urandom);
            dp_in    = 4'($urandom);
            digit_en = 4'($urandom);
            run(int'($urandom_range(5, 90)));
            if ($urandom_range(0, 5) == 0) begin
                clr_n = 1'b0;
                run(int'($urandom_range(1, 3)));
                clr_n = 1'b1;
            end
        end
        run(FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
